// File: rtl/proc_pkg.sv
// Shared types and constants for the 16-bit processor branch path.
package proc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_FLUSH   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_TRUE   = 2'b01,
        COND_FALSE  = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

    // Branch request captured at the handshake
    typedef struct packed {
        cond_e             cond;
        logic              flag;
        logic [DATA_W-1:0] target;
    } br_req_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: (cond, flag) -> taken.
module branch_cond_eval
    import proc_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       flag,
    output logic       taken
);

    // Decode the condition code against the flag
    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: taken = 1'b1;
            COND_TRUE:   taken = flag;
            COND_FALSE:  taken = ~flag;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Conditional branch resolver: owns the PC, flag register and flush sequencing.
module branch_resolver
    import proc_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC     = 16'h0000,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] flag_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_cond,
    input  logic [DATA_W-1:0] br_target,
    input  logic              pc_en,
    output logic [DATA_W-1:0] pc,
    output logic              flag_q,
    output logic              br_taken,
    output logic              flush
);

    state_e            state_q, state_d;
    br_req_t           req_q, req_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_d;
    logic              br_taken_q, br_taken_d;
    logic              flush_q, flush_d;
    logic              taken_c;

    branch_cond_eval u_eval (
        .cond  (req_q.cond),
        .flag  (req_q.flag),
        .taken (taken_c)
    );

    // State, PC, flag and captured request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            br_taken_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            br_taken_q <= br_taken_d;
            flush_q    <= flush_d;
        end
    end

    // Next-state, PC update and handshake logic
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        br_taken_d = 1'b0;
        // A same-cycle flag write bypasses into a captured branch
        flag_d     = flag_we ? (|flag_in) : flag_q;
        br_ready   = (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    req_d.cond   = cond_e'(br_cond);
                    req_d.flag   = flag_d;
                    req_d.target = br_target;
                    state_d      = ST_RESOLVE;
                end else if (pc_en) begin
                    pc_d = pc_q + DATA_W'(1);
                end
            end
            ST_RESOLVE: begin
                if (taken_c) begin
                    pc_d       = req_q.target;
                    br_taken_d = 1'b1;
                    cnt_d      = CNT_W'(FLUSH_CYCLES);
                    state_d    = ST_FLUSH;
                end else begin
                    pc_d    = pc_q + DATA_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flush_d = (state_d == ST_FLUSH);
    end

    assign pc       = pc_q;
    assign br_taken = br_taken_q;
    assign flush    = flush_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: condition table, directed corners, random vs model.
module tb_branch_resolver;

    localparam logic [15:0] RST_PC = 16'h0100;
    localparam int          FC     = 2;

    logic        clk;
    logic        rst;
    logic        flag_we;
    logic [15:0] flag_in;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_cond;
    logic [15:0] br_target;
    logic        pc_en;
    logic [15:0] pc;
    logic        flag_q;
    logic        br_taken;
    logic        flush;

    logic [1:0]  ev_cond;
    logic        ev_flag;
    logic        ev_taken;

    int checks;
    int failures;

    branch_resolver #(
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_target (br_target),
        .pc_en     (pc_en),
        .pc        (pc),
        .flag_q    (flag_q),
        .br_taken  (br_taken),
        .flush     (flush)
    );

    branch_cond_eval u_eval_tb (
        .cond  (ev_cond),
        .flag  (ev_flag),
        .taken (ev_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cond;
        logic       flag;
        logic       exp_taken;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Branch rule written straight from the condition-code table
    function automatic logic rule_taken(input logic [1:0] c, input logic f);
        return (c == 2'd0) || (c == 2'd1 && f) || (c == 2'd2 && !f);
    endfunction

    // Taken branch with cond=00 and full flush wait
    task automatic jump_to(input logic [15:0] tgt);
        br_valid = 1'b1; br_cond = 2'b00; br_target = tgt;
        tick();
        br_valid = 1'b0;
        repeat (1 + FC) tick();
    endtask

    // Reference model: schedule of when outcomes become visible
    logic [15:0] m_pc;
    logic        m_flag;
    logic        m_pulse;
    int          m_wait;
    int          m_flush_left;
    logic        m_pend;
    logic        m_pend_taken;
    logic [15:0] m_pend_tgt;

    task automatic model_step();
        logic eff;
        eff = flag_we ? (flag_in != 16'h0) : m_flag;
        m_pulse = 1'b0;
        if (m_flush_left > 0) m_flush_left--;
        if (m_wait == 0) begin
            if (br_valid) begin
                m_pend       = 1'b1;
                m_pend_taken = rule_taken(br_cond, eff);
                m_pend_tgt   = br_target;
                m_wait       = 1 + (m_pend_taken ? FC : 0);
            end else if (pc_en) begin
                m_pc = m_pc + 16'd1;
            end
        end else begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_pend_taken) begin
                    m_pc         = m_pend_tgt;
                    m_pulse      = 1'b1;
                    m_flush_left = FC;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end
            m_wait--;
        end
        m_flag = eff;
    endtask

    initial begin
        vec_t vecs[8];
        logic req_hold;
        logic [1:0]  rq_cond;
        logic [15:0] rq_tgt;
        logic accepted;

        checks = 0;
        failures = 0;

        vecs[0] = '{2'b00, 1'b0, 1'b1};
        vecs[1] = '{2'b00, 1'b1, 1'b1};
        vecs[2] = '{2'b01, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 1'b1, 1'b1};
        vecs[4] = '{2'b10, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 1'b1, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 1'b1, 1'b0};

        // Standalone condition evaluator table
        for (int i = 0; i < 8; i++) begin
            ev_cond = vecs[i].cond;
            ev_flag = vecs[i].flag;
            #1;
            chk($sformatf("eval_c%0d_f%0d", vecs[i].cond, vecs[i].flag), 32'(ev_taken), 32'(vecs[i].exp_taken));
        end

        rst = 1'b1; flag_we = 1'b0; flag_in = '0; br_valid = 1'b0;
        br_cond = '0; br_target = '0; pc_en = 1'b1;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(RST_PC));
        chk("rst_flag", 32'(flag_q), 0);
        chk("rst_taken", 32'(br_taken), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_ready", 32'(br_ready), 1);

        // Sequential advance after reset release
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("adv_pc%0d", i), 32'(pc), 32'(RST_PC + 16'(i)));
            chk("adv_flush", 32'(flush), 0);
            chk("adv_ready", 32'(br_ready), 1);
        end
        pc_en = 1'b0;

        // Taken branch on true flag
        flag_we = 1'b1; flag_in = 16'hFFFF;
        tick();
        flag_we = 1'b0;
        chk("flag_set", 32'(flag_q), 1);
        br_valid = 1'b1; br_cond = 2'b01; br_target = 16'h0040;
        tick();
        br_valid = 1'b0;
        chk("t_res_ready", 32'(br_ready), 0);
        chk("t_res_pc", 32'(pc), 32'h0103);
        chk("t_res_flush", 32'(flush), 0);
        tick();
        chk("t_pc", 32'(pc), 32'h0040);
        chk("t_taken", 32'(br_taken), 1);
        chk("t_flush1", 32'(flush), 1);
        chk("t_ready1", 32'(br_ready), 0);
        tick();
        chk("t_taken_off", 32'(br_taken), 0);
        chk("t_flush2", 32'(flush), 1);
        chk("t_ready2", 32'(br_ready), 0);
        tick();
        chk("t_flush_end", 32'(flush), 0);
        chk("t_ready_back", 32'(br_ready), 1);

        // Same-cycle flag write bypasses into the branch
        flag_we = 1'b1; flag_in = 16'h0000;
        br_valid = 1'b1; br_cond = 2'b01; br_target = 16'h0040;
        tick();
        flag_we = 1'b0; br_valid = 1'b0;
        chk("byp_flag", 32'(flag_q), 0);
        tick();
        chk("byp_pc", 32'(pc), 32'h0041);
        chk("byp_taken", 32'(br_taken), 0);
        chk("byp_flush", 32'(flush), 0);
        chk("byp_ready", 32'(br_ready), 1);

        // PC wrap and cond=11 from 16'hFFFF
        jump_to(16'hFFFF);
        chk("wrap_pre", 32'(pc), 32'hFFFF);
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        chk("wrap_pc", 32'(pc), 32'h0000);
        jump_to(16'hFFFF);
        br_valid = 1'b1; br_cond = 2'b11; br_target = 16'h1234;
        tick();
        br_valid = 1'b0;
        tick();
        chk("never_pc", 32'(pc), 32'h0000);
        chk("never_taken", 32'(br_taken), 0);
        chk("never_flush", 32'(flush), 0);
        chk("never_ready", 32'(br_ready), 1);

        // Request held through FLUSH is accepted on the first IDLE cycle
        br_valid = 1'b1; br_cond = 2'b00; br_target = 16'h0200;
        tick();
        br_target = 16'h0300; pc_en = 1'b1;
        tick();
        chk("hold_pc1", 32'(pc), 32'h0200);
        chk("hold_ready_f1", 32'(br_ready), 0);
        tick();
        chk("hold_ready_f2", 32'(br_ready), 0);
        tick();
        chk("hold_idle_ready", 32'(br_ready), 1);
        chk("hold_idle_pc", 32'(pc), 32'h0200);
        tick();
        br_valid = 1'b0; pc_en = 1'b0;
        chk("hold_acc_ready", 32'(br_ready), 0);
        chk("hold_acc_pc", 32'(pc), 32'h0200);
        tick();
        chk("hold_pc2", 32'(pc), 32'h0300);
        chk("hold_taken2", 32'(br_taken), 1);
        chk("hold_flush2", 32'(flush), 1);
        repeat (FC) tick();

        // Reset during the second FLUSH cycle
        br_valid = 1'b1; br_cond = 2'b00; br_target = 16'h0500;
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        chk("rf_flush_pre", 32'(flush), 1);
        #2 rst = 1'b1;
        #1;
        chk("rf_flush", 32'(flush), 0);
        chk("rf_pc", 32'(pc), 32'(RST_PC));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rf_ready", 32'(br_ready), 1);
        chk("rf_pc_after", 32'(pc), 32'(RST_PC));
        chk("rf_flush_after", 32'(flush), 0);

        // Randomized run against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pc = RST_PC; m_flag = 1'b0; m_pulse = 1'b0; m_wait = 0;
        m_flush_left = 0; m_pend = 1'b0; m_pend_taken = 1'b0; m_pend_tgt = '0;
        req_hold = 1'b0; rq_cond = '0; rq_tgt = '0;
        for (int i = 0; i < 400; i++) begin
            chk("rnd_pc", 32'(pc), 32'(m_pc));
            chk("rnd_flag", 32'(flag_q), 32'(m_flag));
            chk("rnd_taken", 32'(br_taken), 32'(m_pulse));
            chk("rnd_flush", 32'(flush), 32'(m_flush_left > 0));
            chk("rnd_ready", 32'(br_ready), 32'(m_wait == 0));
            if (!req_hold && $urandom_range(0, 2) == 0) begin
                req_hold = 1'b1;
                rq_cond  = 2'($urandom_range(0, 3));
                rq_tgt   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            end
            br_valid  = req_hold;
            br_cond   = rq_cond;
            br_target = rq_tgt;
            flag_we   = ($urandom_range(0, 2) == 0);
            flag_in   = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'(1 << $urandom_range(0, 15));
            pc_en     = ($urandom_range(0, 9) < 7);
            accepted  = (m_wait == 0) && br_valid;
            model_step();
            if (accepted) req_hold = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
